// File: rtl/rob_commit_ctrl_pkg.sv
// Shared types, sizes and tag arithmetic for the ROB commit controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rob_commit_ctrl_pkg;

    localparam int TAG_W = 4;
    localparam int DEPTH = 1 << TAG_W;
    localparam int VAL_W = 32;
    localparam int REG_W = 5;

    typedef logic [TAG_W-1:0] ROBTagBus;
    typedef logic [REG_W-1:0] RegBus;
    typedef logic [VAL_W-1:0] RegValBus;

    localparam ROBTagBus NO_TAG = '0;

    // One ROB slot: allocation data, completion data and status bits.
    typedef struct packed {
        logic     valid;
        logic     done;
        RegBus    rd;
        RegValBus val;
        RegValBus pc;
        logic     mispredict;
        RegValBus target;
    } rob_entry_t;

    // Tag 0 means "no dependency", so the sequence runs 1..DEPTH-1 and wraps to 1.
    function automatic ROBTagBus tag_inc(input ROBTagBus t);
        return (t == ROBTagBus'(DEPTH - 1)) ? ROBTagBus'(1) : t + ROBTagBus'(1);
    endfunction

endpackage

// File: rtl/rob_commit_ctrl_entry_ram.sv
// ROB entry storage: alloc write, CDB completion write, retire clear, comb read at head.
// Latency: writes visible the cycle after the edge; head read is combinational.
// Backpressure: en_i low freezes every entry; flush_i invalidates all entries.
import rob_commit_ctrl_pkg::*;

module rob_commit_ctrl_entry_ram (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               flush_i,
    input  logic               alloc_we_i,
    input  logic [TAG_W-1:0]   alloc_tag_i,
    input  logic [REG_W-1:0]   alloc_rd_i,
    input  logic [VAL_W-1:0]   alloc_pc_i,
    input  logic               cdb_we_i,
    input  logic [TAG_W-1:0]   cdb_tag_i,
    input  logic [VAL_W-1:0]   cdb_val_i,
    input  logic               cdb_mis_i,
    input  logic [VAL_W-1:0]   cdb_tgt_i,
    input  logic               retire_i,
    input  logic [TAG_W-1:0]   head_tag_i,
    output logic               head_valid_o,
    output logic               head_done_o,
    output logic [REG_W-1:0]   head_rd_o,
    output logic [VAL_W-1:0]   head_val_o,
    output logic [VAL_W-1:0]   head_pc_o,
    output logic               head_mis_o,
    output logic [VAL_W-1:0]   head_tgt_o
);

    rob_entry_t mem_q [DEPTH];

    // Entry updates; completion only lands on live entries, a fresh alloc overrides a retire.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (en_i) begin
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i].valid <= 1'b0;
                    mem_q[i].done  <= 1'b0;
                end
            end else begin
                if (cdb_we_i && mem_q[cdb_tag_i].valid) begin
                    mem_q[cdb_tag_i].done       <= 1'b1;
                    mem_q[cdb_tag_i].val        <= cdb_val_i;
                    mem_q[cdb_tag_i].mispredict <= cdb_mis_i;
                    mem_q[cdb_tag_i].target     <= cdb_tgt_i;
                end
                if (retire_i) begin
                    mem_q[head_tag_i].valid <= 1'b0;
                    mem_q[head_tag_i].done  <= 1'b0;
                end
                if (alloc_we_i) begin
                    mem_q[alloc_tag_i].valid      <= 1'b1;
                    mem_q[alloc_tag_i].done       <= 1'b0;
                    mem_q[alloc_tag_i].rd         <= alloc_rd_i;
                    mem_q[alloc_tag_i].pc         <= alloc_pc_i;
                    mem_q[alloc_tag_i].mispredict <= 1'b0;
                end
            end
        end
    end

    assign head_valid_o = mem_q[head_tag_i].valid;
    assign head_done_o  = mem_q[head_tag_i].done;
    assign head_rd_o    = mem_q[head_tag_i].rd;
    assign head_val_o   = mem_q[head_tag_i].val;
    assign head_pc_o    = mem_q[head_tag_i].pc;
    assign head_mis_o   = mem_q[head_tag_i].mispredict;
    assign head_tgt_o   = mem_q[head_tag_i].target;

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order ROB tag allocator and commit sequencer; flushes on a mispredicted branch at head.
// Latency: CDB edge -> commit outputs one edge later; one retirement per cycle.
// Backpressure: alloc_gnt low when full or flushing; rdy_in low freezes all state.
import rob_commit_ctrl_pkg::*;

module rob_commit_ctrl (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               alloc_req,
    input  logic [REG_W-1:0]   alloc_rd,
    input  logic [VAL_W-1:0]   alloc_pc,
    output logic               alloc_gnt,
    output logic [TAG_W-1:0]   next_tag,
    output logic               full,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [VAL_W-1:0]   cdb_val,
    input  logic               cdb_mispredict,
    input  logic [VAL_W-1:0]   cdb_target,
    output logic               write_rdy,
    output logic [REG_W-1:0]   rd,
    output logic [VAL_W-1:0]   write_val,
    output logic [TAG_W-1:0]   now_tag,
    output logic               clear,
    output logic [VAL_W-1:0]   redirect_pc,
    output logic               commit_pulse,
    output logic [VAL_W-1:0]   commit_pc
);

    ROBTagBus head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic     write_rdy_q, write_rdy_d, clear_q, clear_d, pulse_q, pulse_d;
    RegBus    rd_q, rd_d;
    RegValBus wval_q, wval_d, redir_q, redir_d, cpc_q, cpc_d;

    logic     h_valid, h_done, h_mis;
    RegBus    h_rd;
    RegValBus h_val, h_pc, h_tgt;
    logic     commit_fire, flush, cdb_we;

    // The flush cycle (clear_q) blocks alloc, completion and retirement.
    assign full        = (count_q == ROBTagBus'(DEPTH - 1));
    assign alloc_gnt   = alloc_req && !full && !clear_q;
    assign next_tag    = tail_q;
    assign cdb_we      = cdb_valid && !clear_q && (cdb_tag != NO_TAG);
    assign commit_fire = !clear_q && h_valid && h_done;
    assign flush       = commit_fire && h_mis;

    rob_commit_ctrl_entry_ram u_ram (
        .clk_i        (clk_in),
        .rst_i        (rst_in),
        .en_i         (rdy_in),
        .flush_i      (flush),
        .alloc_we_i   (alloc_gnt),
        .alloc_tag_i  (tail_q),
        .alloc_rd_i   (alloc_rd),
        .alloc_pc_i   (alloc_pc),
        .cdb_we_i     (cdb_we),
        .cdb_tag_i    (cdb_tag),
        .cdb_val_i    (cdb_val),
        .cdb_mis_i    (cdb_mispredict),
        .cdb_tgt_i    (cdb_target),
        .retire_i     (commit_fire),
        .head_tag_i   (head_q),
        .head_valid_o (h_valid),
        .head_done_o  (h_done),
        .head_rd_o    (h_rd),
        .head_val_o   (h_val),
        .head_pc_o    (h_pc),
        .head_mis_o   (h_mis),
        .head_tgt_o   (h_tgt)
    );

    // Next-state for pointers, occupancy and the registered commit/flush outputs.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        write_rdy_d = commit_fire && (h_rd != '0);
        pulse_d     = commit_fire;
        clear_d     = flush;
        rd_d        = rd_q;
        wval_d      = wval_q;
        cpc_d       = cpc_q;
        redir_d     = redir_q;
        if (commit_fire) begin
            rd_d   = h_rd;
            wval_d = h_val;
            cpc_d  = h_pc;
        end
        if (flush) begin
            head_d  = ROBTagBus'(1);
            tail_d  = ROBTagBus'(1);
            count_d = '0;
            redir_d = h_tgt;
        end else begin
            if (alloc_gnt)   tail_d = tag_inc(tail_q);
            if (commit_fire) head_d = tag_inc(head_q);
            count_d = count_q + {{(TAG_W-1){1'b0}}, alloc_gnt} - {{(TAG_W-1){1'b0}}, commit_fire};
        end
    end

    // State register: reset beats the global enable, which otherwise freezes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q      <= ROBTagBus'(1);
            tail_q      <= ROBTagBus'(1);
            count_q     <= '0;
            write_rdy_q <= 1'b0;
            pulse_q     <= 1'b0;
            clear_q     <= 1'b0;
            rd_q        <= '0;
            wval_q      <= '0;
            cpc_q       <= '0;
            redir_q     <= '0;
        end else if (rdy_in) begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            write_rdy_q <= write_rdy_d;
            pulse_q     <= pulse_d;
            clear_q     <= clear_d;
            rd_q        <= rd_d;
            wval_q      <= wval_d;
            cpc_q       <= cpc_d;
            redir_q     <= redir_d;
        end
    end

    assign write_rdy    = write_rdy_q;
    assign rd           = rd_q;
    assign write_val    = wval_q;
    assign now_tag      = head_q;
    assign clear        = clear_q;
    assign redirect_pc  = redir_q;
    assign commit_pulse = pulse_q;
    assign commit_pc    = cpc_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: hand-computed vector table, directed corner sequences, random traffic.
// Latency: inputs driven after posedge, comb outputs sampled at negedge, registered ones at posedge+1.
// Backpressure: exercises full, flush and rdy_in freeze.
module tb_rob_commit_ctrl;

    logic        clk = 1'b0;
    logic        d_rst, d_rdy, d_req, d_cv, d_mis;
    logic [4:0]  d_rd;
    logic [31:0] d_pc, d_cval, d_tgt;
    logic [3:0]  d_ct;

    logic        alloc_gnt, full, write_rdy, clear, commit_pulse;
    logic [3:0]  next_tag, now_tag;
    logic [4:0]  rd;
    logic [31:0] write_val, redirect_pc, commit_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rob_commit_ctrl dut (
        .clk_in(clk), .rst_in(d_rst), .rdy_in(d_rdy),
        .alloc_req(d_req), .alloc_rd(d_rd), .alloc_pc(d_pc),
        .alloc_gnt(alloc_gnt), .next_tag(next_tag), .full(full),
        .cdb_valid(d_cv), .cdb_tag(d_ct), .cdb_val(d_cval),
        .cdb_mispredict(d_mis), .cdb_target(d_tgt),
        .write_rdy(write_rdy), .rd(rd), .write_val(write_val), .now_tag(now_tag),
        .clear(clear), .redirect_pc(redirect_pc),
        .commit_pulse(commit_pulse), .commit_pc(commit_pc)
    );

    // ---------------- reference model: in-order queue of live instructions ----------------
    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] val;
        logic [31:0] tgt;
        bit          done;
        bit          mis;
    } ment_t;

    ment_t       mq[$];
    logic [3:0]  m_tail;
    logic        m_wr, m_pulse, m_clear;
    logic [4:0]  m_rd;
    logic [31:0] m_val, m_pc, m_redir;

    function automatic logic [3:0] tinc(input logic [3:0] t);
        return 4'((int'(t) % 15) + 1);
    endfunction

    function automatic logic [3:0] m_head();
        return (mq.size() > 0) ? mq[0].tag : m_tail;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_tail = 4'd1; m_wr = 0; m_pulse = 0; m_clear = 0;
        m_rd = 0; m_val = 0; m_pc = 0; m_redir = 0;
    endtask

    task automatic model_update();
        bit    gnt, com;
        ment_t h, e;
        if (d_rst) begin
            model_reset();
        end else if (d_rdy) begin
            if (m_clear) begin
                m_clear = 0; m_wr = 0; m_pulse = 0;
            end else begin
                gnt = d_req && (mq.size() < 15);
                com = (mq.size() > 0) && mq[0].done;
                if (com) h = mq[0];
                if (d_cv) begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (mq[i].tag == d_ct) begin
                            e = mq[i]; e.done = 1; e.val = d_cval; e.mis = d_mis; e.tgt = d_tgt;
                            mq[i] = e;
                        end
                    end
                end
                m_wr = 0; m_pulse = 0;
                if (com) begin
                    void'(mq.pop_front());
                    m_wr = (h.rd != 0); m_rd = h.rd; m_val = h.val; m_pc = h.pc; m_pulse = 1;
                    if (h.mis) begin
                        mq.delete(); m_tail = 4'd1; m_clear = 1; m_redir = h.tgt; gnt = 0;
                    end
                end
                if (gnt) begin
                    e.tag = m_tail; e.rd = d_rd; e.pc = d_pc; e.val = 0; e.tgt = 0; e.done = 0; e.mis = 0;
                    mq.push_back(e);
                    m_tail = tinc(m_tail);
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic q, input logic [4:0] d, input logic [31:0] p,
                          input logic c, input logic [3:0] t, input logic [31:0] v,
                          input logic mi, input logic [31:0] tg, input logic ry);
        d_rst = r; d_req = q; d_rd = d; d_pc = p; d_cv = c; d_ct = t; d_cval = v;
        d_mis = mi; d_tgt = tg; d_rdy = ry;
    endtask

    task automatic cyc_pre();
        @(negedge clk);
        chk("alloc_gnt", alloc_gnt, !m_clear && d_req && (mq.size() < 15));
        chk("full", full, mq.size() == 15);
        chk("next_tag", next_tag, m_tail);
    endtask

    task automatic cyc_post();
        @(posedge clk);
        model_update();
        #1;
        chk("write_rdy", write_rdy, m_wr);
        chk("commit_pulse", commit_pulse, m_pulse);
        chk("now_tag", now_tag, m_head());
        chk("clear", clear, m_clear);
        if (m_pulse) begin
            chk("rd", rd, m_rd);
            chk("write_val", write_val, m_val);
            chk("commit_pc", commit_pc, m_pc);
        end
        if (m_clear) chk("redirect_pc", redirect_pc, m_redir);
    endtask

    task automatic cyc(input logic r, input logic q, input logic [4:0] d, input logic [31:0] p,
                       input logic c, input logic [3:0] t, input logic [31:0] v,
                       input logic mi, input logic [31:0] tg, input logic ry);
        set_in(r, q, d, p, c, t, v, mi, tg, ry);
        cyc_pre();
        cyc_post();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // ---------------- hand-computed vector table ----------------
    typedef struct {
        logic        rst, req;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cval;
        logic        egnt;
        logic [3:0]  ent;
        logic        ewr;
        logic [4:0]  erd;
        logic [31:0] eval;
        logic [3:0]  enow;
        logic        epulse;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        //        rst req rd  pc      cv ct cval     gnt nt  wr rd val      now pulse
        tbl[0]  = '{1, 0, 0, 0,       0, 0, 0,       0,  1,  0, 0, 0,       1,  0};
        tbl[1]  = '{0, 1, 5, 'h100,   0, 0, 0,       1,  1,  0, 0, 0,       1,  0};
        tbl[2]  = '{0, 0, 0, 0,       1, 1, 'h1234,  0,  2,  0, 0, 0,       1,  0};
        tbl[3]  = '{0, 0, 0, 0,       0, 0, 0,       0,  2,  1, 5, 'h1234,  2,  1};
        tbl[4]  = '{0, 0, 0, 0,       0, 0, 0,       0,  2,  0, 0, 0,       2,  0};
        tbl[5]  = '{1, 0, 0, 0,       0, 0, 0,       0,  2,  0, 0, 0,       1,  0};
        tbl[6]  = '{0, 1, 1, 'h10,    0, 0, 0,       1,  1,  0, 0, 0,       1,  0};
        tbl[7]  = '{0, 1, 2, 'h14,    0, 0, 0,       1,  2,  0, 0, 0,       1,  0};
        tbl[8]  = '{0, 1, 3, 'h18,    0, 0, 0,       1,  3,  0, 0, 0,       1,  0};
        tbl[9]  = '{0, 0, 0, 0,       1, 3, 'h33,    0,  4,  0, 0, 0,       1,  0};
        tbl[10] = '{0, 0, 0, 0,       1, 2, 'h22,    0,  4,  0, 0, 0,       1,  0};
        tbl[11] = '{0, 0, 0, 0,       1, 1, 'h11,    0,  4,  0, 0, 0,       1,  0};
        tbl[12] = '{0, 0, 0, 0,       0, 0, 0,       0,  4,  1, 1, 'h11,    2,  1};
        tbl[13] = '{0, 0, 0, 0,       0, 0, 0,       0,  4,  1, 2, 'h22,    3,  1};
        tbl[14] = '{0, 0, 0, 0,       0, 0, 0,       0,  4,  1, 3, 'h33,    4,  1};
        tbl[15] = '{0, 0, 0, 0,       0, 0, 0,       0,  4,  0, 0, 0,       4,  0};

        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].rst, tbl[i].req, tbl[i].rd, tbl[i].pc, tbl[i].cv, tbl[i].ct, tbl[i].cval, 0, 0, 1);
            cyc_pre();
            chk("tbl_gnt", alloc_gnt, tbl[i].egnt);
            chk("tbl_next_tag", next_tag, tbl[i].ent);
            cyc_post();
            chk("tbl_write_rdy", write_rdy, tbl[i].ewr);
            chk("tbl_now_tag", now_tag, tbl[i].enow);
            chk("tbl_pulse", commit_pulse, tbl[i].epulse);
            if (tbl[i].epulse) begin
                chk("tbl_rd", rd, tbl[i].erd);
                chk("tbl_write_val", write_val, tbl[i].eval);
            end
        end
        chk("tbl_empty_full", full, 0);

        // ---- fill to full, wrap tail, commit one, re-grant tag 1, wrap now_tag ----
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 15; i++) cyc(0, 1, 5'(i), 32'(i * 4), 0, 0, 0, 0, 0, 1);
        set_in(0, 1, 9, 'h99, 0, 0, 0, 0, 0, 1);
        cyc_pre();
        chk("full_at_15", full, 1);
        chk("gnt_when_full", alloc_gnt, 0);
        chk("tail_wrap", next_tag, 1);
        cyc_post();
        cyc(0, 0, 0, 0, 1, 1, 'hAAA1, 0, 0, 1);
        set_in(0, 1, 9, 'h99, 0, 0, 0, 0, 0, 1);
        cyc_pre();
        chk("gnt_full_during_commit", alloc_gnt, 0);
        cyc_post();
        set_in(0, 1, 9, 'h99, 0, 0, 0, 0, 0, 1);
        cyc_pre();
        chk("gnt_after_commit", alloc_gnt, 1);
        chk("regrant_tag1", next_tag, 1);
        cyc_post();
        for (int i = 2; i <= 15; i++) cyc(0, 0, 0, 0, 1, 4'(i), 32'(i + 'h500), 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1, 'h501, 0, 0, 1);
        repeat (18) idle();
        chk("now_tag_after_wrap", now_tag, 2);
        chk("next_tag_after_wrap", next_tag, 2);

        // ---- mispredict at tag 2 with tags 3,4 pending ----
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 5'(i), 32'('h40 + i * 4), 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1, 'hA1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 2, 'hA2, 1, 'h80, 1);
        idle();
        chk("mis_clear", clear, 1);
        chk("mis_redirect", redirect_pc, 'h80);
        chk("mis_write_rdy", write_rdy, 1);
        chk("mis_rd", rd, 2);
        set_in(0, 1, 7, 'h70, 1, 3, 'hA3, 0, 0, 1);
        cyc_pre();
        chk("flush_next_tag", next_tag, 1);
        chk("flush_gnt", alloc_gnt, 0);
        cyc_post();
        chk("clear_drops", clear, 0);
        chk("no_commit_in_flush", commit_pulse, 0);
        cyc(0, 0, 0, 0, 1, 3, 'hA3, 0, 0, 1);
        repeat (3) idle();
        chk("stale_cdb_ignored", commit_pulse, 0);

        // ---- rd=0 commit, then rdy_in freeze ----
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 'h200, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1, 'h5, 0, 0, 1);
        idle();
        chk("rd0_write_rdy", write_rdy, 0);
        chk("rd0_pulse", commit_pulse, 1);
        for (int i = 7; i <= 9; i++) cyc(0, 1, 5'(i), 32'(i * 16), 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 2, 'h77, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 3, 'h300, 1, 3, 'h88, 1, 'h44, 0);
            cyc_pre();
            chk("freeze_next_tag", next_tag, 5);
            cyc_post();
            chk("freeze_now_tag", now_tag, 2);
        end
        repeat (4) idle();

        // ---- reset with 6 entries live, rdy_in low ----
        for (int i = 1; i <= 6; i++) cyc(0, 1, 5'(i), 32'(i), 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 5'(m_head()), 'h66, 0, 0, 1);
        cyc(1, 1, 4, 'h4, 1, 3, 'h9, 0, 0, 0);
        chk("rst_now_tag", now_tag, 1);
        chk("rst_write_rdy", write_rdy, 0);
        chk("rst_clear", clear, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc_pre();
        chk("rst_next_tag", next_tag, 1);
        chk("rst_full", full, 0);
        cyc_post();

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] t;
            t = 4'($urandom_range(0, 15));
            if (mq.size() > 0 && ($urandom % 4) != 0) t = mq[$urandom_range(0, mq.size() - 1)].tag;
            cyc(($urandom % 400) == 0, ($urandom % 3) != 0, 5'($urandom), $urandom,
                ($urandom % 5) < 3, t, $urandom, ($urandom % 20) == 0, $urandom,
                ($urandom % 10) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
